// File: rtl/cmplx_mul_seq.sv
// cmplx_mul_seq: sequential signed complex multiply over one shared unsigned 16x16 multiplier.
// Optional A*conj(B) mode with conj_b port when CMPLX_MUL_CONJ_EN is defined.
module cmplx_mul_seq #(
  parameter int W = 16,
  parameter int MUL_LAT = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a_re,
  input  logic [W-1:0]   a_im,
  input  logic [W-1:0]   b_re,
  input  logic [W-1:0]   b_im,
`ifdef CMPLX_MUL_CONJ_EN
  input  logic           conj_b,
`endif
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_p,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W:0]   p_re,
  output logic [2*W:0]   p_im,
  output logic           busy
);
  localparam int CW = MUL_LAT > 0 ? $clog2(MUL_LAT + 1) : 1;
  typedef enum logic [1:0] {IDLE, MUL, OUT} state_t;
  state_t state_q, state_d;
  logic [2:0] k_q, k_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] ar_q, ar_d, ai_q, ai_d, br_q, br_d, bi_q, bi_d, ma_q, ma_d, mb_q, mb_d;
  logic conj_q, conj_d, pend_q, pend_d;
  logic [2*W:0] prod_q, prod_d, re_q, re_d, im_q, im_d, ext;
  logic conj_in, fire, sub, neg;
  logic [1:0] kn;
  logic [W-1:0] xs, ys, xn, yn;
`ifdef CMPLX_MUL_CONJ_EN
  assign conj_in = conj_b;
`else
  assign conj_in = 1'b0;
`endif
  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return v[W-1] ? -v : v;
  endfunction
  always_comb begin
    fire = state_q == MUL && k_q != 3'd4 && cnt_q == CW'(MUL_LAT);
    kn = k_q[1:0] + 2'd1;
    xs = k_q[0] ? ai_q : ar_q;
    ys = (k_q[0] == k_q[1]) ? br_q : bi_q;
    xn = kn[0] ? ai_q : ar_q;
    yn = (kn[0] == kn[1]) ? br_q : bi_q;
    sub = k_q == 3'd1 ? !conj_q : k_q == 3'd2 ? conj_q : 1'b0;
    neg = xs[W-1] ^ ys[W-1] ^ sub;
    ext = {1'b0, mul_p};
    state_d = state_q;
    k_d = k_q;
    cnt_d = cnt_q;
    ar_d = ar_q;
    ai_d = ai_q;
    br_d = br_q;
    bi_d = bi_q;
    ma_d = ma_q;
    mb_d = mb_q;
    conj_d = conj_q;
    prod_d = prod_q;
    pend_d = fire;
    re_d = pend_q && (k_q == 3'd1 || k_q == 3'd2) ? re_q + prod_q : re_q;
    im_d = pend_q && (k_q == 3'd3 || k_q == 3'd4) ? im_q + prod_q : im_q;
    if (state_q == IDLE && in_valid) begin
      state_d = MUL;
      ar_d = a_re;
      ai_d = a_im;
      br_d = b_re;
      bi_d = b_im;
      conj_d = conj_in;
      ma_d = mag(a_re);
      mb_d = mag(b_re);
      k_d = '0;
      cnt_d = '0;
      re_d = '0;
      im_d = '0;
    end else if (state_q == MUL) begin
      state_d = k_q == 3'd4 ? OUT : MUL;
      cnt_d = fire ? '0 : cnt_q + CW'(1);
      if (fire) begin
        prod_d = neg ? -ext : ext;
        k_d = k_q + 3'd1;
        ma_d = k_q == 3'd3 ? ma_q : mag(xn);
        mb_d = k_q == 3'd3 ? mb_q : mag(yn);
      end
    end else if (state_q == OUT && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q <= '0;
      cnt_q <= '0;
      ar_q <= '0;
      ai_q <= '0;
      br_q <= '0;
      bi_q <= '0;
      ma_q <= '0;
      mb_q <= '0;
      conj_q <= 1'b0;
      pend_q <= 1'b0;
      prod_q <= '0;
      re_q <= '0;
      im_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      cnt_q <= cnt_d;
      ar_q <= ar_d;
      ai_q <= ai_d;
      br_q <= br_d;
      bi_q <= bi_d;
      ma_q <= ma_d;
      mb_q <= mb_d;
      conj_q <= conj_d;
      pend_q <= pend_d;
      prod_q <= prod_d;
      re_q <= re_d;
      im_q <= im_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign busy = !in_ready;
  assign out_valid = state_q == OUT;
  assign mul_a = ma_q;
  assign mul_b = mb_q;
  assign p_re = re_q;
  assign p_im = im_q;
endmodule
